io_periph: RTL and testbench
============================

Name: io_periph

Overview:
Memory-mapped I/O responder on the I/O side of the data-memory address decoder.
- Accepts the decoded I/O write enable and the window-relative offset (0x00–0xFF).
- Provides combinational read data to the data-memory read mux.
- Holds the LED output register, a synchronized switch input, a scratch register and a prescaled down-counting timer with an interrupt request.

Parameters:
LED_W, 16, LED output register width (1..32)
SW_W, 16, switch input width (1..32)
PRESCALE, 4, clk cycles per timer tick (>=1); prescaler counter width = clog2(PRESCALE)+1

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
io_we  input  1  write strobe from the address decoder, one write per cycle it is high
io_addr  input  32  window-relative byte offset; may be X when io_we=0 and the access is not I/O
io_wdata  input  32  store data
io_rdata  output  32  combinational read data for io_addr
led  output  LED_W  LED register
sw  input  SW_W  asynchronous switch inputs
irq  output  1  timer interrupt request, level

Behaviour:
- Decode: io_addr[1:0] ignored (word access only). io_addr[31:8] != 0 is unmapped: reads 0, writes ignored.
- Register map, by byte offset:
  - 0x00 LED, RW, low LED_W bits.
  - 0x04 SW, RO, 2-flop synchronized sw, zero-extended.
  - 0x08 CTRL, RW, bits [2:0] = {irq_en, auto_reload, enable}.
  - 0x0C LOAD, RW, 32 bits.
  - 0x10 COUNT, RO, 32 bits.
  - 0x14 STATUS, bit0 = expired, write-1-to-clear.
  - 0x18 SCRATCH, RW, 32 bits.
  - Other offsets in the window read 0 and ignore writes.
  - Unused bits read 0.
- Reset: all registers, sync flops and the prescaler reset to 0 → led=0, irq=0, io_rdata reflects zeroed state.
- Writes: take effect on the rising edge where io_we=1. Value is visible on io_rdata the following cycle.
- Reads: purely combinational from the current register state, zero latency. SW reads show sw with 2-cycle synchronizer latency.
- Prescaler:
  - Counts 0..PRESCALE-1 while enable=1.
  - The tick is asserted on the cycle it equals PRESCALE-1, then it wraps to 0.
  - Held at 0 while enable=0.
- Timer, on tick:
  - COUNT != 0: COUNT decrements.
  - COUNT == 0: expired is set. If auto_reload=1, COUNT <= LOAD. Otherwise enable is cleared and COUNT stays 0.
- LOAD write: also copies io_wdata into COUNT and clears the prescaler in the same edge. This takes priority over the tick decrement.
- CTRL write: enable 0→1 does not reload COUNT. Software writes LOAD first.
- STATUS write with bit0=1 clears expired. If an expiry occurs in the same cycle, set wins and expired stays 1.
- Hardware clearing of enable and a same-cycle CTRL write: the CTRL write wins.
- irq = expired & irq_en, registered-free (combinational from flops).
- LOAD = 0 with auto_reload=1: expires on every tick.
- Asynchronous reset asserted mid-count: the timer stops immediately, all state returns to 0.

Decomposition:
- Shared package/header io_map holds:
  - Offset constants IO_LED, IO_SW, IO_CTRL, IO_LOAD, IO_COUNT, IO_STATUS, IO_SCRATCH.
  - CTRL bit indices.
  - The I/O window base/end, also used by the address decoder.
- One sub-module io_timer (prescaler + counter + expired flag).
  - Inputs: ctrl bits, load strobe/value, clear strobe.
  - Outputs: COUNT, expired, hardware enable-clear pulse.
- The top level holds registers, the synchronizer and the read mux.

Test Plan:
1. Reset then read all offsets 0x00–0x1C and 0x80 → all 0, irq=0. Write 0xDEADBEEF to 0x18 → reads 0xDEADBEEF next cycle. Write to 0x80 → no register changes.
2. Write 0xFFFF_A5A5 to 0x00 with LED_W=16 → led=0xA5A5, read 0x00 = 0x0000A5A5. Drive sw=0x1234 → read 0x04 = 0x1234 exactly 2 cycles later, 0 before.
3. PRESCALE=4, LOAD=3, CTRL=0b101 → COUNT 3,2,1,0 at 4-cycle steps. Expired and irq set on the next tick. Enable clears, COUNT holds 0.
4. LOAD=2, CTRL=0b111 → expiry every 12 cycles, COUNT reloads to 2. Write 1 to 0x14 → irq drops next cycle, reasserts at the next expiry.
5. STATUS clear written in the same cycle as expiry → expired remains 1. Write LOAD=5 during a tick cycle → COUNT=5, no decrement.
6. Assert rst_n=0 mid-count for a partial cycle → led, COUNT, CTRL, irq go 0 asynchronously. Timer idle after release.

Source files
------------

// File: rtl/io_map_pkg.sv
// I/O window map shared by io_periph and the data-memory address decoder.
// Offsets are byte offsets relative to the 256-byte I/O window.
package io_map;

  localparam logic [31:0] IO_WIN_BASE = 32'hFFFF_FF00;
  localparam logic [31:0] IO_WIN_END  = 32'hFFFF_FFFF;

  localparam logic [7:0] IO_LED     = 8'h00;
  localparam logic [7:0] IO_SW      = 8'h04;
  localparam logic [7:0] IO_CTRL    = 8'h08;
  localparam logic [7:0] IO_LOAD    = 8'h0C;
  localparam logic [7:0] IO_COUNT   = 8'h10;
  localparam logic [7:0] IO_STATUS  = 8'h14;
  localparam logic [7:0] IO_SCRATCH = 8'h18;

  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;
  localparam int CTRL_IE = 2;

  function automatic logic io_mapped(input logic [31:0] addr);
    return addr[31:8] == 24'h0;
  endfunction

endpackage

// File: rtl/io_timer.sv
// Prescaled 32-bit down-counter with sticky expired flag.
// A LOAD write suppresses the tick of that cycle entirely and restarts the prescaler.
module io_timer
  import io_map::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic        i_auto_reload,
  input  logic        i_load_we,
  input  logic [31:0] i_load_val,
  input  logic [31:0] i_reload_val,
  input  logic        i_clr,
  output logic [31:0] o_count,
  output logic        o_expired,
  output logic        o_hw_clr_en
);

  localparam int PW = $clog2(PRESCALE) + 1;

  logic [PW-1:0] r_pre;
  logic [31:0]   r_count;
  logic          r_expired;
  logic          w_tick;
  logic          w_expire;

  assign w_tick      = i_enable && !i_load_we && (r_pre == PW'(PRESCALE - 1));
  assign w_expire    = w_tick && (r_count == 32'h0);
  assign o_hw_clr_en = w_expire && !i_auto_reload;
  assign o_count     = r_count;
  assign o_expired   = r_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (i_load_we || !i_enable || w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load_we) begin
      r_count <= i_load_val;
    end else if (w_tick) begin
      if (r_count != 32'h0) begin
        r_count <= r_count - 32'h1;
      end else if (i_auto_reload) begin
        r_count <= i_reload_val;
      end
    end
  end

  // Set beats a same-cycle software clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_expired <= 1'b0;
    end else if (w_expire) begin
      r_expired <= 1'b1;
    end else if (i_clr) begin
      r_expired <= 1'b0;
    end
  end

endmodule

// File: rtl/io_periph.sv
// Memory-mapped I/O responder: LED, synchronized switches, scratch and timer.
// Read data is combinational from register state; writes land on the strobe edge.
module io_periph
  import io_map::*;
#(
  parameter int LED_W    = 16,
  parameter int SW_W     = 16,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             io_we,
  input  logic [31:0]      io_addr,
  input  logic [31:0]      io_wdata,
  output logic [31:0]      io_rdata,
  output logic [LED_W-1:0] led,
  input  logic [SW_W-1:0]  sw,
  output logic             irq
);

  logic [LED_W-1:0] r_led;
  logic [SW_W-1:0]  r_sw_s1;
  logic [SW_W-1:0]  r_sw_s2;
  logic [2:0]       r_ctrl;
  logic [31:0]      r_load;
  logic [31:0]      r_scratch;

  logic [7:0]  w_off;
  logic        w_wr;
  logic        w_load_we;
  logic        w_ctrl_we;
  logic        w_clr;
  logic        w_hw_clr_en;
  logic [31:0] w_count;
  logic        w_expired;

  assign w_off     = io_addr[7:0] & 8'hFC;
  assign w_wr      = io_we && io_mapped(io_addr);
  assign w_load_we = w_wr && (w_off == IO_LOAD);
  assign w_ctrl_we = w_wr && (w_off == IO_CTRL);
  assign w_clr     = w_wr && (w_off == IO_STATUS) && io_wdata[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led     <= '0;
      r_load    <= '0;
      r_scratch <= '0;
    end else if (w_wr) begin
      if (w_off == IO_LED)     r_led     <= io_wdata[LED_W-1:0];
      if (w_off == IO_LOAD)    r_load    <= io_wdata;
      if (w_off == IO_SCRATCH) r_scratch <= io_wdata;
    end
  end

  // A software CTRL write overrides the timer's own enable clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= '0;
    end else if (w_ctrl_we) begin
      r_ctrl <= io_wdata[2:0];
    end else if (w_hw_clr_en) begin
      r_ctrl[CTRL_EN] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
    end
  end

  io_timer #(
    .PRESCALE(PRESCALE)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (r_ctrl[CTRL_EN]),
    .i_auto_reload(r_ctrl[CTRL_AR]),
    .i_load_we    (w_load_we),
    .i_load_val   (io_wdata),
    .i_reload_val (r_load),
    .i_clr        (w_clr),
    .o_count      (w_count),
    .o_expired    (w_expired),
    .o_hw_clr_en  (w_hw_clr_en)
  );

  always_comb begin
    io_rdata = 32'h0;
    if (io_mapped(io_addr)) begin
      case (w_off)
        IO_LED:     io_rdata = 32'(r_led);
        IO_SW:      io_rdata = 32'(r_sw_s2);
        IO_CTRL:    io_rdata = {29'h0, r_ctrl};
        IO_LOAD:    io_rdata = r_load;
        IO_COUNT:   io_rdata = w_count;
        IO_STATUS:  io_rdata = {31'h0, w_expired};
        IO_SCRATCH: io_rdata = r_scratch;
        default:    io_rdata = 32'h0;
      endcase
    end
  end

  assign led = r_led;
  assign irq = w_expired && r_ctrl[CTRL_IE];

endmodule

// File: tb/tb_io_periph.sv
// Scoreboard bench for io_periph: directed timer scenarios then random traffic,
// checked against a register-map level reference model.
module tb_io_periph;

  localparam int LED_W    = 16;
  localparam int SW_W     = 16;
  localparam int PRESCALE = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             io_we;
  logic [31:0]      io_addr;
  logic [31:0]      io_wdata;
  logic [31:0]      io_rdata;
  logic [LED_W-1:0] led;
  logic [SW_W-1:0]  sw;
  logic             irq;

  io_periph #(.LED_W(LED_W), .SW_W(SW_W), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst_n(rst_n), .io_we(io_we), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .led(led), .sw(sw), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state, named after the register map.
  logic [LED_W-1:0] m_led;
  logic [2:0]       m_ctrl;
  logic [31:0]      m_load, m_count, m_scratch;
  logic             m_exp;
  logic [SW_W-1:0]  m_sw1, m_sw2;
  int               m_pre;

  always @(posedge clk or negedge rst_n) begin
    logic        wr, lw, tick, en, ar;
    logic [7:0]  off;
    logic [2:0]  n_ctrl;
    logic [31:0] n_count;
    logic        n_exp;
    int          n_pre;
    if (!rst_n) begin
      m_led = '0; m_ctrl = '0; m_load = '0; m_count = '0; m_scratch = '0;
      m_exp = 1'b0; m_sw1 = '0; m_sw2 = '0; m_pre = 0;
    end else begin
      off  = io_addr[7:0] & 8'hFC;
      wr   = io_we && (io_addr[31:8] == 24'h0);
      lw   = wr && off == 8'h0C;
      en   = m_ctrl[0];
      ar   = m_ctrl[1];
      tick = en && !lw && (m_pre == PRESCALE - 1);
      n_pre   = (!en || lw || tick) ? 0 : m_pre + 1;
      n_ctrl  = m_ctrl;
      n_count = m_count;
      n_exp   = m_exp;
      if (wr && off == 8'h14 && io_wdata[0]) n_exp = 1'b0;
      if (tick) begin
        if (m_count != 0) n_count = m_count - 1;
        else begin
          n_exp = 1'b1;
          if (ar) n_count = m_load;
          else    n_ctrl[0] = 1'b0;
        end
      end
      if (lw) n_count = io_wdata;
      if (wr && off == 8'h08) n_ctrl = io_wdata[2:0];
      if (wr && off == 8'h00) m_led = io_wdata[LED_W-1:0];
      if (wr && off == 8'h0C) m_load = io_wdata;
      if (wr && off == 8'h18) m_scratch = io_wdata;
      m_sw2 = m_sw1;
      m_sw1 = sw;
      m_ctrl = n_ctrl; m_count = n_count; m_exp = n_exp; m_pre = n_pre;
    end
  end

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:8] != 24'h0) return 32'h0;
    case (a[7:0] & 8'hFC)
      8'h00:   return 32'(m_led);
      8'h04:   return 32'(m_sw2);
      8'h08:   return {29'h0, m_ctrl};
      8'h0C:   return m_load;
      8'h10:   return m_count;
      8'h14:   return {31'h0, m_exp};
      8'h18:   return m_scratch;
      default: return 32'h0;
    endcase
  endfunction

  typedef struct {
    logic [31:0]      addr;
    logic [31:0]      rd;
    logic [LED_W-1:0] led;
    logic             irq;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("rdata@%h", e.addr), io_rdata, e.rd);
      chk("led", 32'(led), 32'(e.led));
      chk("irq", 32'(irq), 32'(e.irq));
    end
  end

  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    io_we = we; io_addr = a; io_wdata = d;
    #1;
    e.addr = a; e.rd = m_read(a); e.led = m_led; e.irq = m_exp & m_ctrl[2];
    sb.push_back(e);
  endtask

  task automatic rd_n(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, a, 32'h0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    io_we = 1'b0; io_addr = 32'h10;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_count", io_rdata, 32'h0);
    io_addr = 32'h08;
    #1;
    chk("rst_ctrl", io_rdata, 32'h0);
    rst_n = 1'b1;
  endtask

  logic [31:0] offs [10] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10,
                             32'h14, 32'h18, 32'h1C, 32'h80, 32'h104};

  initial begin
    rst_n = 1'b0; io_we = 1'b0; io_addr = 32'h0; io_wdata = 32'h0; sw = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) cyc(1'b0, 32'(i * 4), 32'h0);
    cyc(1'b0, 32'h80, 32'h0);
    cyc(1'b1, 32'h18, 32'hDEADBEEF);
    rd_n(32'h18, 2);
    cyc(1'b1, 32'h80, 32'hFFFFFFFF);
    cyc(1'b1, 32'h100, 32'hFFFFFFFF);
    for (int i = 0; i < 8; i++) cyc(1'b0, 32'(i * 4), 32'h0);

    cyc(1'b1, 32'h00, 32'hFFFFA5A5);
    rd_n(32'h00, 1);
    sw = 16'h1234;
    rd_n(32'h04, 4);

    cyc(1'b1, 32'h0C, 32'd3);
    cyc(1'b1, 32'h08, 32'h5);
    rd_n(32'h10, 24);
    rd_n(32'h08, 2);

    cyc(1'b1, 32'h0C, 32'd2);
    cyc(1'b1, 32'h08, 32'h7);
    rd_n(32'h10, 30);
    cyc(1'b1, 32'h14, 32'h1);
    rd_n(32'h14, 20);

    cyc(1'b1, 32'h0C, 32'd0);
    cyc(1'b1, 32'h08, 32'h7);
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h14, 32'h1);
    rd_n(32'h14, 3);
    cyc(1'b1, 32'h0C, 32'd9);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 32'h0C, 32'd5);
      rd_n(32'h10, 1);
    end
    rd_n(32'h10, 10);

    cyc(1'b1, 32'h00, 32'h0000BEEF);
    cyc(1'b1, 32'h0C, 32'd100);
    cyc(1'b1, 32'h08, 32'h7);
    rd_n(32'h10, 10);
    async_reset();
    rd_n(32'h10, 12);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, d;
      a = offs[$urandom_range(0, 9)] | 32'($urandom_range(0, 3));
      d = $urandom;
      if ((a[7:0] & 8'hFC) == 8'h0C && a[31:8] == 0) d = 32'($urandom_range(0, 6));
      if ((a[7:0] & 8'hFC) == 8'h14 && ($urandom_range(0, 3) != 0)) d = 32'h0;
      if ($urandom_range(0, 15) == 0) sw = SW_W'($urandom);
      if ($urandom_range(0, 999) == 0) async_reset();
      else cyc(1'($urandom_range(0, 2) == 0 ? 0 : 1) & 1'($urandom_range(0, 1)), a, d);
    end

    rd_n(32'h10, 2);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
